// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, default
// parameter values and a parameter legality helper.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  // 10 ms at 100 MHz; benches use the short value to keep runs small.
  localparam int unsigned DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned SIM_STABLE_CYCLES = 8;
  localparam int unsigned DEF_CNT_W         = 20;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  function automatic logic params_ok(input int unsigned stable_cycles,
                                     input int unsigned cnt_w,
                                     input int unsigned sync_stages);
    return (stable_cycles >= 2) && (sync_stages >= 2) &&
           ((64'd1 << cnt_w) >= 64'(stable_cycles));
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key signal bundle between the board key, the debouncer and its consumers.
interface key_debouncer_if;

  logic key_i;
  logic key_o;
  logic key_press;
  logic key_release;

  modport master (
    output key_i,
    input  key_o,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_i,
    output key_o,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_sync.sv
// SYNC_STAGES-deep flop chain bringing the raw key into the system_clk domain.
module key_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic system_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizer, stability counter and 4-state FSM
// producing a clean level plus registered press/release strobes.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE_LOW  | key accepted as released, waiting for key_s to go high
// WAIT_HIGH | key_s high, counting stable cycles before accepting press
// IDLE_HIGH | key accepted as pressed, waiting for key_s to go low
// WAIT_LOW  | key_s low, counting stable cycles before accepting release
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic            system_clk,
  input  logic            reset,
  key_debouncer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (!params_ok(STABLE_CYCLES, CNT_W, SYNC_STAGES)) begin : g_bad_params
    $error("key_debouncer: illegal STABLE_CYCLES/CNT_W/SYNC_STAGES");
  end

  logic             key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_o_q, key_o_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key_sync (
    .system_clk(system_clk),
    .reset     (reset),
    .d         (bus.key_i),
    .q         (key_s)
  );

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      key_o_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_o_q   <= key_o_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // A bounce back to the stable level drops all accumulated count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_o_d   = key_o_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        cnt_d = '0;
        if (key_s) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (!key_s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          key_o_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        cnt_d = '0;
        if (!key_s) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (key_s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          key_o_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        key_o_d = 1'b0;
      end
    endcase
  end

  assign bus.key_o       = key_o_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a run-length reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_key_debouncer;
  import key_debouncer_pkg::*;

  localparam int unsigned STABLE = SIM_STABLE_CYCLES;
  localparam int unsigned STAGES = 2;
  localparam int unsigned LAT    = STAGES + STABLE + 1;

  logic system_clk = 1'b0;
  logic reset      = 1'b0;

  key_debouncer_if bus ();

  key_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4),
    .SYNC_STAGES  (STAGES)
  ) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 system_clk = ~system_clk;

  typedef struct packed {
    logic key_o;
    logic press;
    logic rel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  int press_count  = 0;
  int rel_count    = 0;
  int last_press   = -1;
  int last_rel     = -1;

  // Reference model: the key as seen by the decision logic lags key_i by
  // STAGES edges; a level is accepted once it differs from the output for
  // STABLE+1 consecutive observations.
  logic ref_pipe[$];
  logic ref_out = 1'b0;
  int   ref_run = 0;

  always @(posedge system_clk) begin
    logic seen;
    exp_t e;
    cycle++;
    e = '0;
    if (!reset) begin
      ref_pipe = {};
      for (int i = 0; i < int'(STAGES); i++) ref_pipe.push_back(1'b0);
      ref_out = 1'b0;
      ref_run = 0;
    end else begin
      seen = ref_pipe.pop_front();
      ref_pipe.push_back(bus.key_i);
      if (seen == ref_out) begin
        ref_run = 0;
      end else begin
        ref_run++;
        if (ref_run == int'(STABLE) + 1) begin
          ref_out = seen;
          ref_run = 0;
          e.press = seen;
          e.rel   = !seen;
        end
      end
      e.key_o = ref_out;
    end
    exp_q.push_back(e);
  end

  always @(negedge system_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({bus.key_o, bus.key_press, bus.key_release} !== e) begin
        miscompares++;
        $display("FAIL scoreboard cycle %0d: o/press/rel got %b%b%b want %b%b%b",
                 cycle, bus.key_o, bus.key_press, bus.key_release,
                 e.key_o, e.press, e.rel);
      end
    end
    if (bus.key_press === 1'b1) begin
      press_count++;
      last_press = cycle;
    end
    if (bus.key_release === 1'b1) begin
      rel_count++;
      last_rel = cycle;
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge system_clk);
    #1;
  endtask

  task automatic assert_reset_now(input string tag);
    #1;
    reset = 1'b0;
    #1;
    check({tag, "_async_key_o"},   int'(bus.key_o),       0);
    check({tag, "_async_press"},   int'(bus.key_press),   0);
    check({tag, "_async_release"}, int'(bus.key_release), 0);
    check({tag, "_async_state"},   int'(dut.state_q),     int'(IDLE_LOW));
  endtask

  initial begin
    int c0, p0, r0;
    bus.key_i = 1'b0;
    reset     = 1'b0;

    wait_cycles(3);
    check("reset_key_o", int'(bus.key_o), 0);
    check("reset_press", int'(bus.key_press), 0);
    check("reset_state", int'(dut.state_q), int'(IDLE_LOW));
    reset = 1'b1;
    wait_cycles(4);

    // clean press
    p0 = press_count; r0 = rel_count;
    bus.key_i = 1'b1; c0 = cycle;
    wait_cycles(LAT + 3);
    check("press_count", press_count - p0, 1);
    check("press_latency", last_press - c0, int'(LAT));
    check("press_key_o", int'(bus.key_o), 1);
    check("press_no_release", rel_count - r0, 0);

    // hold, then clean release
    wait_cycles(20);
    r0 = rel_count;
    bus.key_i = 1'b0; c0 = cycle;
    wait_cycles(LAT + 3);
    check("release_count", rel_count - r0, 1);
    check("release_latency", last_rel - c0, int'(LAT));
    check("release_key_o", int'(bus.key_o), 0);

    // short glitch
    p0 = press_count;
    bus.key_i = 1'b1;
    wait_cycles(5);
    bus.key_i = 1'b0;
    wait_cycles(15);
    check("glitch_press", press_count - p0, 0);
    check("glitch_key_o", int'(bus.key_o), 0);
    check("glitch_state", int'(dut.state_q), int'(IDLE_LOW));

    // bounce train, then a settled press
    p0 = press_count;
    for (int i = 0; i < 10; i++) begin
      bus.key_i = ~bus.key_i;
      wait_cycles(3);
    end
    bus.key_i = 1'b1; c0 = cycle;
    wait_cycles(LAT + 3);
    check("bounce_press_count", press_count - p0, 1);
    check("bounce_latency", last_press - c0, int'(LAT));
    bus.key_i = 1'b0;
    wait_cycles(LAT + 3);

    // reset four cycles into WAIT_HIGH
    p0 = press_count;
    bus.key_i = 1'b1;
    wait_cycles(int'(STAGES) + 1 + 4);
    assert_reset_now("midwait");
    wait_cycles(3);
    check("midwait_no_press", press_count - p0, 0);

    // key held through reset release
    p0 = press_count;
    reset = 1'b1; c0 = cycle;
    wait_cycles(LAT + 3);
    check("held_press_count", press_count - p0, 1);
    check("held_latency", last_press - c0, int'(LAT));
    check("held_key_o", int'(bus.key_o), 1);

    // randomized segments with occasional reset pulses
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        assert_reset_now("rand");
        wait_cycles(2);
        reset = 1'b1;
      end
      bus.key_i = 1'($urandom_range(0, 1));
      wait_cycles(int'($urandom_range(1, 14)));
    end

    bus.key_i = 1'b0;
    wait_cycles(LAT + 3);
    check("final_key_o", int'(bus.key_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
